// File: rtl/cpu_pkg.sv
// Types and default widths shared across the CPU front end.
package cpu_pkg;

    localparam int FQ_ADDR_W  = 7;
    localparam int FQ_INSTR_W = 32;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0]  pc_plus1;
        logic [FQ_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port and a priority clear.
module sync_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC counter, combinational imem port and a
// run-ahead queue of {pc+1, instr} entries drained by decode.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = FQ_ADDR_W,
    parameter int INSTR_W = FQ_INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc_plus1,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef struct packed {
        logic [ADDR_W-1:0]  pc_plus1;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic              push;
    logic              pop;
    entry_t            wentry;
    entry_t            head;

    // Redirect suppresses both handshakes so the head shown that cycle is dropped.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = fetch_en && !redirect_valid && ((count != FULL_CNT) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    assign imem_addr       = pc;
    assign wentry.pc_plus1 = pc + ADDR_W'(1);
    assign wentry.instr    = imem_data;

    sync_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .clear(redirect_valid),
        .wdata(wentry),
        .rdata(head),
        .count(count)
    );

    assign out_instr    = out_valid ? head.instr    : '0;
    assign out_pc_plus1 = out_valid ? head.pc_plus1 : '0;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined CPU. It replaces the single PC register and the IF/ID register with three parts: a PC counter, a combinational instruction-memory address port, and a DEPTH-entry first-word-fall-through queue of {pc+1, instruction} pairs.
- The decode stage consumes entries with a valid/ready handshake.
- Jumps, jump-registers and taken branches flush the queue through a single redirect port.
- Fetch can run ahead of decode stalls, up to DEPTH entries.

## Interface
Parameters:
- ADDR_W, 7, instruction-memory word-address width; the PC wraps modulo 2^ADDR_W.
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_addr  out  ADDR_W  current fetch PC; driven combinationally from the PC register.
- imem_data  in  INSTR_W  instruction at imem_addr; the memory reads combinationally in the same cycle.
- fetch_en  in  1  when 0, no push and the PC holds; pops and redirects still act.
- redirect_valid  in  1  flush the queue and load a new PC (J, JR, taken branch).
- redirect_pc  in  ADDR_W  new fetch PC.
- out_valid  out  1  queue head holds a valid entry.
- out_ready  in  1  decode accepts the head (replaces IFID_write).
- out_instr  out  INSTR_W  instruction at the queue head.
- out_pc_plus1  out  ADDR_W  address of the head instruction plus 1, mod 2^ADDR_W; feeds the branch adder.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- pop = out_valid & out_ready & ~redirect_valid.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
  - Pushing while full is allowed only together with a pop.
- On push:
  - The entry {imem_addr + 1, imem_data} is written at the write pointer.
  - PC <= PC + 1. This wraps from 2^ADDR_W-1 to 0; entry PC arithmetic wraps the same way.
- On pop: the read pointer advances.
- count update on each edge: +1 for push only, -1 for pop only, unchanged when both or neither occur.
- Redirect has priority over every other event in the same cycle:
  - read pointer, write pointer and count go to 0;
  - PC <= redirect_pc;
  - no push or pop takes effect;
  - the entry on the outputs that cycle is discarded, not consumed.
- The head is shown first-word-fall-through:
  - out_instr and out_pc_plus1 come from storage at the read pointer;
  - out_valid = (count != 0);
  - out_instr and out_pc_plus1 read 0 when out_valid is 0.
- The pointers are log2(DEPTH) bits wide and wrap naturally.
- Illegal parameters (DEPTH not a power of two, or DEPTH < 2) are caught by an elaboration-time check.

## Timing
- Reset values:
  - PC = 0, so imem_addr = 0;
  - pointers = 0, count = 0;
  - out_valid = 0, out_instr = 0, out_pc_plus1 = 0;
  - storage contents are don't-care.
- A reset asserted mid-operation clears everything immediately, asynchronously.
- After reset release, the first rising edge with fetch_en=1 pushes address 0. out_valid is 1 after that edge.
- Fetch-to-decode latency is 1 cycle: an instruction addressed in cycle n is at the head in cycle n+1 if the queue was empty.
- With out_ready held at 1, throughput is 1 instruction per cycle and count stays at 1.
- With out_ready held at 0, count rises by 1 per cycle up to DEPTH, then the PC holds.
- Redirect asserted in cycle n:
  - in cycle n+1, out_valid=0 and imem_addr=redirect_pc;
  - in cycle n+2, the head is the instruction at redirect_pc.
  - This gives a 2-cycle bubble with no stale entry ever presented.
- Simultaneous pop and push at full: count stays at DEPTH and there is no bubble.
- Simultaneous pop and push at count=1: out_valid stays 1 and the head advances to the newly fetched entry.

## Structure
- Shared package cpu_pkg:
  - ADDR_W and INSTR_W defaults;
  - typedef fetch_entry_t = struct {pc_plus1, instr}.
- One sub-module: sync_fifo.
  - Parameters: WIDTH, DEPTH. Ports: push, pop, clear, data in/out, count.
  - clear has priority over push and pop.
  - fetch_queue owns the PC register, the push/pop/redirect logic, and one sync_fifo instance of fetch_entry_t.

## Test plan
- Free-run: reset, then fetch_en=1, out_ready=1, with imem[k]=k+100.
  - Head sequence is 100, 101, 102…; out_pc_plus1 is 1, 2, 3…; count stays at 1.
- Backpressure: out_ready=0 for 6 cycles with DEPTH=4.
  - count goes 1, 2, 3, 4, 4, 4; imem_addr freezes at 4.
  - After out_ready=1, the heads are 100..103 and then 104, with no gap and no duplicate.
- Redirect at full: queue full, then redirect_valid with redirect_pc=40 and out_ready=1 in the same cycle.
  - The next cycle has count=0 and out_valid=0.
  - The cycle after that has head 140 and out_pc_plus1=41. The popped-looking head is not counted as consumed.
- PC wrap: redirect_pc=127 with ADDR_W=7.
  - Heads are imem[127] with out_pc_plus1=0, then imem[0] with out_pc_plus1=1.
- fetch_en=0 with out_ready=1 and 2 entries queued:
  - both entries drain; out_valid then drops to 0; imem_addr is unchanged throughout.
- Asynchronous reset between clock edges with 3 entries queued:
  - out_valid, count and imem_addr go to 0 before the next edge.
